// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 16-channel mux select sequencer.
package mux_scan_pkg;
   localparam int NCH       = 16;
   localparam int SEL_W     = 4;
   localparam int CNT_W     = 8;
   localparam int DWELL_MIN = 1;
   localparam int DWELL_MAX = 255;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_DONE
   } state_t;
endpackage

// File: rtl/mux_scan_next.sv
// Combinational finder for the lowest enabled channel strictly above i_sel,
// or at/above channel 0 when i_from_zero is set.
module mux_scan_next
   import mux_scan_pkg::*;
(
   input  logic [NCH-1:0]   i_mask,
   input  logic [SEL_W-1:0] i_sel,
   input  logic             i_from_zero,
   output logic [SEL_W-1:0] o_next_sel,
   output logic             o_has_next
);
   logic [NCH-1:0] w_cand;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_cand
         assign w_cand[gi] = i_mask[gi] & (i_from_zero | (SEL_W'(gi) > i_sel));
      end
   endgenerate

   // Walk downwards so the last hit written is the lowest candidate.
   always_comb begin
      o_next_sel = '0;
      o_has_next = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (w_cand[i]) begin
            o_next_sel = SEL_W'(i);
            o_has_next = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer: walks the mux select over the enabled channels, holds each
// for DWELL cycles and captures the mux output into a parallel result word.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int DWELL = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [NCH-1:0]   i_mask,
   input  logic             i_f,
   output logic [SEL_W-1:0] o_sel,
   output logic             o_busy,
   output logic             o_done,
   output logic [NCH-1:0]   o_data
);
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DWELL - 1);

   state_t           r_state;
   logic [SEL_W-1:0] r_sel;
   logic [CNT_W-1:0] r_cnt;
   logic [NCH-1:0]   r_mask_q;
   logic [NCH-1:0]   r_data;

   state_t           w_state_next;
   logic [SEL_W-1:0] w_sel_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic [NCH-1:0]   w_mask_next;
   logic [NCH-1:0]   w_data_next;

   logic [NCH-1:0]   w_find_mask;
   logic             w_from_zero;
   logic [SEL_W-1:0] w_next_sel;
   logic             w_has_next;

   // In IDLE the finder searches the incoming mask from bit 0 to pick the first channel.
   assign w_from_zero = (r_state == ST_IDLE);
   assign w_find_mask = w_from_zero ? i_mask : r_mask_q;

   mux_scan_next u_next (
      .i_mask      (w_find_mask),
      .i_sel       (r_sel),
      .i_from_zero (w_from_zero),
      .o_next_sel  (w_next_sel),
      .o_has_next  (w_has_next)
   );

   always_comb begin
      w_state_next = r_state;
      w_sel_next   = r_sel;
      w_cnt_next   = r_cnt;
      w_mask_next  = r_mask_q;
      w_data_next  = r_data;
      if (i_abort) begin
         w_state_next = ST_IDLE;
         w_sel_next   = '0;
         w_cnt_next   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  w_mask_next = i_mask;
                  w_data_next = '0;
                  w_cnt_next  = '0;
                  if (w_has_next) begin
                     w_sel_next   = w_next_sel;
                     w_state_next = ST_SETTLE;
                  end else begin
                     w_state_next = ST_DONE;
                  end
               end
            end
            ST_SETTLE: begin
               if (r_cnt == LP_LAST) begin
                  w_data_next[r_sel] = i_f;
                  w_cnt_next         = '0;
                  if (w_has_next) begin
                     w_sel_next = w_next_sel;
                  end else begin
                     w_state_next = ST_DONE;
                  end
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               w_state_next = ST_IDLE;
               w_sel_next   = '0;
            end
            default: begin
               w_state_next = ST_IDLE;
               w_sel_next   = '0;
               w_cnt_next   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_sel    <= '0;
         r_cnt    <= '0;
         r_mask_q <= '0;
         r_data   <= '0;
      end else begin
         r_state  <= w_state_next;
         r_sel    <= w_sel_next;
         r_cnt    <= w_cnt_next;
         r_mask_q <= w_mask_next;
         r_data   <= w_data_next;
      end
   end

   assign o_sel  = r_sel;
   assign o_busy = (r_state == ST_SETTLE);
   assign o_done = (r_state == ST_DONE);
   assign o_data = r_data;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench: three sequencers (DWELL 1/2/3) share stimulus, each drives
// its own behavioural 16:1 mux fed from the common input word a.
module tb_mux_scan_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] mask = '0;
   logic [15:0] a = '0;

   logic [3:0]  sel1, sel2, sel3;
   logic        busy1, busy2, busy3;
   logic        done1, done2, done3;
   logic [15:0] data1, data2, data3;
   logic        f1, f2, f3;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign f1 = a[sel1];
   assign f2 = a[sel2];
   assign f3 = a[sel3];

   mux_scan_ctrl #(.DWELL(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_mask(mask),
      .i_f(f1), .o_sel(sel1), .o_busy(busy1), .o_done(done1), .o_data(data1));
   mux_scan_ctrl #(.DWELL(2)) u_d2 (
      .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_mask(mask),
      .i_f(f2), .o_sel(sel2), .o_busy(busy2), .o_done(done2), .o_data(data2));
   mux_scan_ctrl #(.DWELL(3)) u_d3 (
      .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_mask(mask),
      .i_f(f3), .o_sel(sel3), .o_busy(busy3), .o_done(done3), .o_data(data3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      start = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   // Returns just after the accepting edge E0.
   task automatic accept(input logic [15:0] m);
      mask  = m;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_tests++; if (sel1 !== 4'd0) begin n_fail++; $display("FAIL reset_sel got=%0d exp=0", sel1); end
      n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy1); end
      n_tests++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done1); end
      n_tests++; if (data1 !== 16'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0000", data1); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      $display("[TB] test_reset done");
   endtask

   task automatic test_full_scan();
      idle_all();
      a = 16'hAAAA;
      accept(16'hFFFF);
      for (int k = 0; k < 16; k++) begin
         n_tests++;
         if (sel1 !== 4'(k) || busy1 !== 1'b1 || done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL full_step%0d got sel=%0d busy=%b done=%b exp sel=%0d busy=1 done=0", k, sel1, busy1, done1, k);
         end
         tick();
      end
      n_tests++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin n_fail++; $display("FAIL full_done got done=%b busy=%b exp done=1 busy=0", done1, busy1); end
      n_tests++; if (data1 !== 16'hAAAA) begin n_fail++; $display("FAIL full_data got=%h exp=AAAA", data1); end
      tick();
      n_tests++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL full_done_width got=%b exp=0", done1); end
      $display("[TB] test_full_scan data=%h", data1);
   endtask

   task automatic test_dwell3();
      idle_all();
      a = 16'hAAAA;
      accept(16'h00F0);
      for (int j = 0; j < 12; j++) begin
         n_tests++;
         if (sel3 !== 4'(4 + j / 3) || busy3 !== 1'b1 || done3 !== 1'b0) begin
            n_fail++;
            $display("FAIL dwell3_cyc%0d got sel=%0d busy=%b done=%b exp sel=%0d busy=1 done=0", j, sel3, busy3, done3, 4 + j / 3);
         end
         tick();
      end
      n_tests++; if (done3 !== 1'b1) begin n_fail++; $display("FAIL dwell3_done got=%b exp=1", done3); end
      n_tests++; if (data3 !== 16'h00A0) begin n_fail++; $display("FAIL dwell3_data got=%h exp=00A0", data3); end
      tick();
      n_tests++; if (done3 !== 1'b0) begin n_fail++; $display("FAIL dwell3_done_width got=%b exp=0", done3); end
      $display("[TB] test_dwell3 data=%h", data3);
   endtask

   task automatic test_empty_mask();
      idle_all();
      accept(16'h0000);
      n_tests++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL empty_done got=%b exp=1", done1); end
      n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL empty_busy got=%b exp=0", busy1); end
      n_tests++; if (data1 !== 16'h0) begin n_fail++; $display("FAIL empty_data got=%h exp=0000", data1); end
      tick();
      n_tests++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL empty_after got done=%b busy=%b exp 0 0", done1, busy1); end
      $display("[TB] test_empty_mask data=%h", data1);
   endtask

   task automatic test_drop_start();
      int done_cnt = 0;
      idle_all();
      a = 16'h8001;
      accept(16'h8001);
      mask = 16'h0002;
      n_tests++; if (sel2 !== 4'd0 || busy2 !== 1'b1) begin n_fail++; $display("FAIL drop_e0 got sel=%0d busy=%b exp 0 1", sel2, busy2); end
      tick();
      if (done2) done_cnt++;
      start = 1'b1;
      tick();
      start = 1'b0;
      if (done2) done_cnt++;
      n_tests++; if (sel2 !== 4'd15 || busy2 !== 1'b1) begin n_fail++; $display("FAIL drop_sel15 got sel=%0d busy=%b exp 15 1", sel2, busy2); end
      tick();
      if (done2) done_cnt++;
      tick();
      if (done2) done_cnt++;
      n_tests++; if (done2 !== 1'b1 || data2 !== 16'h8001) begin n_fail++; $display("FAIL drop_done got done=%b data=%h exp 1 8001", done2, data2); end
      start = 1'b1;
      tick();
      start = 1'b0;
      if (done2) done_cnt++;
      n_tests++; if (busy2 !== 1'b0 || sel2 !== 4'd0) begin n_fail++; $display("FAIL drop_idle got busy=%b sel=%0d exp 0 0", busy2, sel2); end
      tick();
      if (done2) done_cnt++;
      n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL drop_not_queued got busy=%b exp 0", busy2); end
      n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL drop_done_count got=%0d exp=1", done_cnt); end
      $display("[TB] test_drop_start data=%h", data2);
   endtask

   task automatic test_abort();
      int done_cnt = 0;
      idle_all();
      a = 16'hFFFF;
      accept(16'hFFFF);
      for (int k = 0; k < 5; k++) tick();
      n_tests++; if (sel1 !== 4'd5) begin n_fail++; $display("FAIL abort_pre_sel got=%0d exp=5", sel1); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_tests++; if (sel1 !== 4'd0 || busy1 !== 1'b0 || done1 !== 1'b0) begin n_fail++; $display("FAIL abort_idle got sel=%0d busy=%b done=%b exp 0 0 0", sel1, busy1, done1); end
      n_tests++; if (data1 !== 16'h001F) begin n_fail++; $display("FAIL abort_data got=%h exp=001F", data1); end
      for (int k = 0; k < 20; k++) begin
         tick();
         if (done1) done_cnt++;
      end
      n_tests++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
      $display("[TB] test_abort data=%h", data1);
   endtask

   task automatic test_reset_mid();
      idle_all();
      a = 16'hFFFF;
      accept(16'hFFFF);
      tick();
      tick();
      n_tests++; if (data1 !== 16'h0003) begin n_fail++; $display("FAIL rstmid_pre_data got=%h exp=0003", data1); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_tests++; if (sel1 !== 4'd0 || busy1 !== 1'b0 || done1 !== 1'b0 || data1 !== 16'h0) begin
         n_fail++;
         $display("FAIL rstmid_async got sel=%0d busy=%b done=%b data=%h exp all 0", sel1, busy1, done1, data1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      a = 16'h0002;
      accept(16'h0003);
      n_tests++; if (sel1 !== 4'd0 || busy1 !== 1'b1) begin n_fail++; $display("FAIL rstmid_e0 got sel=%0d busy=%b exp 0 1", sel1, busy1); end
      tick();
      n_tests++; if (sel1 !== 4'd1) begin n_fail++; $display("FAIL rstmid_sel1 got=%0d exp=1", sel1); end
      tick();
      n_tests++; if (done1 !== 1'b1 || data1 !== 16'h0002) begin n_fail++; $display("FAIL rstmid_result got done=%b data=%h exp 1 0002", done1, data1); end
      $display("[TB] test_reset_mid data=%h", data1);
   endtask

   initial begin
      test_reset();
      test_full_scan();
      test_dwell3();
      test_empty_mask();
      test_drop_start();
      test_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
